// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// controller state encoding and default parameter widths.
package seq_det_pkg;

  // Controller states; the encoding is visible to software debug readout.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam int DEF_PAT_W = 6;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/pattern_matcher.sv
// Bit-serial pattern matcher. Keeps the last PAT_W-1 qualified bits plus a
// saturating fill count, and flags a hit combinationally when the incoming
// bit completes the pattern. History is never cleared on a hit, so
// overlapping occurrences are all reported.
module pattern_matcher #(
  parameter int PAT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             x_valid,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  // Fill only has to reach PAT_W-1, i.e. "history fully populated".
  localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic [PAT_W-1:0]  cand_s;
  logic              take_s;

  assign take_s = en & x_valid;
  assign cand_s = {hist_r, x};
  assign hit    = take_s & (fill_r >= FILL_FULL) & (cand_s == pattern);

  // Shift qualified bits into the history and advance the fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (clr) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (take_s) begin
      hist_r <= cand_s[PAT_W-2:0];
      if (fill_r != FILL_FULL) begin
        fill_r <= fill_r + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence-detect controller: latches pattern/target/window on start,
// counts overlapping hits while armed and retires with a done or timeout
// pulse. Abort returns to idle silently, keeping the hit count visible.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] target,
  input  logic [WIN_W-1:0] window,
  input  logic             x_valid,
  input  logic             x,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timeout
);

  state_t           state_r, state_s;
  logic [PAT_W-1:0] pattern_r;
  logic [CNT_W-1:0] target_r;
  logic [WIN_W-1:0] window_r;
  logic [WIN_W-1:0] timer_r, timer_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             load_s;
  logic             armed_s;
  logic             hit_s;
  logic             match_s;
  logic             complete_s;
  logic             expire_s;
  logic             busy_r, match_r, done_r, timeout_r;

  assign armed_s = (state_r == ST_ARMED);

  pattern_matcher #(
    .PAT_W(PAT_W)
  ) u_matcher (
    .clk     (clk),
    .rst     (rst),
    .clr     (load_s),
    .en      (armed_s),
    .x_valid (x_valid),
    .x       (x),
    .pattern (pattern_r),
    .hit     (hit_s)
  );

  // Next-state, counter and timer decisions; abort beats done beats timeout.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    timer_s    = timer_r;
    load_s     = 1'b0;
    match_s    = 1'b0;
    complete_s = 1'b0;
    expire_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          count_s = '0;
          timer_s = '0;
          if (target == '0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ARMED;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        timer_s  = timer_r + WIN_W'(1);
        expire_s = (window_r != '0) && (timer_r == (window_r - WIN_W'(1)));
        if (hit_s) begin
          match_s    = 1'b1;
          complete_s = (({1'b0, count_r} + (CNT_W+1)'(1)) == {1'b0, target_r});
          if (count_r != {CNT_W{1'b1}}) begin
            count_s = count_r + CNT_W'(1);
          end else begin
            count_s = count_r;
          end
        end else begin
          match_s    = 1'b0;
          complete_s = 1'b0;
        end
        if (abort) begin
          state_s = ST_IDLE;
        end else if (complete_s) begin
          state_s = ST_DONE;
        end else if (expire_s) begin
          state_s = ST_TIMEOUT;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_TIMEOUT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      timer_r   <= '0;
      busy_r    <= 1'b0;
      match_r   <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      timer_r   <= timer_s;
      busy_r    <= (state_s != ST_IDLE);
      match_r   <= match_s;
      done_r    <= (state_s == ST_DONE);
      timeout_r <= (state_s == ST_TIMEOUT);
    end
  end

  // Run configuration, captured only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_r <= '0;
      target_r  <= '0;
      window_r  <= '0;
    end else if (load_s) begin
      pattern_r <= pattern;
      target_r  <= target;
      window_r  <= window;
    end
  end

  assign busy        = busy_r;
  assign match       = match_r;
  assign match_count = count_r;
  assign done        = done_r;
  assign timeout     = timeout_r;

endmodule
